// File: rtl/bru_resolve_pipe.sv
// rtl/bru_resolve_pipe.sv - branch/jump resolution stage with elastic registered output
//
// Resolves conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR:
// direction, taken target, link address, mispredict flag and the corrected
// next PC. The result travels through LATENCY valid/ready register stages.
//
// Optional feature macro: BRU_PERF_CNT_EN
//   defined   -> saturating resolved-op and mispredict counters
//   undefined -> counter ports tied to zero
//
// Parameters
//   XLEN     data/address width (>= 8)
//   LATENCY  register stages from input to output (1 or 2)
//   CNT_W    performance counter width
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   valid_i / ready_o      input handshake
//   pc_i, rs1_data_i, rs2_data_i, imm_i
//                          instruction PC, operands, sign-extended immediate
//   is_br_i, is_jal_i, is_jalr_i, funct3_i
//                          op class and branch condition code
//   pred_taken_i, pred_target_i
//                          fetch-stage prediction being checked
//   flush_i                kill every in-flight op and the op offered this cycle
//   valid_o / ready_i      output handshake
//   taken_o, target_o, link_o, mispredict_o, redirect_pc_o
//                          resolved result
//   br_cnt_o, mispred_cnt_o
//                          performance counters

module bru_resolve_pipe #(
    parameter int XLEN    = 32,
    parameter int LATENCY = 1,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             is_br_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic             pred_taken_i,
    input  logic [XLEN-1:0]  pred_target_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             taken_o,
    output logic [XLEN-1:0]  target_o,
    output logic [XLEN-1:0]  link_o,
    output logic             mispredict_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    typedef struct packed {
        logic            cf;        // op was a branch/JAL/JALR (counter qualifier)
        logic            taken;
        logic            mis;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] link;
        logic [XLEN-1:0] redirect;
    } pay_t;

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    // ------------------------------------------------------------------
    // Resolution logic
    // ------------------------------------------------------------------
    logic [XLEN:0]   diff;
    logic            eq;
    logic            ltu;
    logic            ovf;
    logic            lt;
    logic            cond;
    logic            taken;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            mis;
    pay_t            new_pay;

    always_comb begin
        // One subtractor yields all three relations; the extra top bit is
        // the carry out, which is clear exactly when rs1 < rs2 unsigned.
        diff = {1'b0, rs1_data_i} + {1'b0, ~rs2_data_i} + (XLEN+1)'(1);
        eq   = (diff[XLEN-1:0] == '0);
        ltu  = ~diff[XLEN];
        ovf  = (rs1_data_i[XLEN-1] ^ rs2_data_i[XLEN-1]) &
               (rs1_data_i[XLEN-1] ^ diff[XLEN-1]);
        lt   = diff[XLEN-1] ^ ovf;

        cond = 1'b0;
        case (funct3_i)
            3'b000:  cond = eq;
            3'b001:  cond = ~eq;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase

        // Jumps win over a simultaneously flagged conditional branch.
        taken    = is_jal_i | is_jalr_i | (is_br_i & cond);
        jalr_sum = rs1_data_i + imm_i;
        target   = is_jalr_i ? (jalr_sum & JALR_MASK) : (pc_i + imm_i);
        link     = pc_i + XLEN'(4);
        mis      = (taken != pred_taken_i) |
                   (taken & pred_taken_i & (target != pred_target_i));

        new_pay.cf       = is_br_i | is_jal_i | is_jalr_i;
        new_pay.taken    = taken;
        new_pay.mis      = mis;
        new_pay.target   = target;
        new_pay.link     = link;
        new_pay.redirect = taken ? target : link;
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] vld_q;
    pay_t               pay_q [LATENCY];
    logic [LATENCY-1:0] load;
    logic [LATENCY:0]   up_v;
    pay_t               up_p  [LATENCY+1];

    // Stage k loads when empty or when its content leaves this cycle. The
    // chain is walked from the output backwards so a full pipe still moves
    // one op per cycle while ready_i is high.
    always_comb begin
        logic drain;
        load  = '0;
        drain = ready_i;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            load[k] = ~vld_q[k] | drain;
            drain   = load[k];
        end
    end

    // Upstream view of each stage: index 0 is the input port, k+1 is stage k.
    // An op offered during a flush is discarded here, before stage 0.
    always_comb begin
        up_v    = {vld_q, valid_i & ~flush_i};
        up_p[0] = new_pay;
        for (int k = 0; k < LATENCY; k++) begin
            up_p[k+1] = pay_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                if (flush_i) begin
                    vld_q[k] <= 1'b0;
                end else if (load[k]) begin
                    vld_q[k] <= up_v[k];
                end
                // Payload only moves with a real op; bubbles leave it alone.
                if (load[k] && up_v[k]) begin
                    pay_q[k] <= up_p[k];
                end
            end
        end
    end

    assign ready_o       = load[0];
    assign valid_o       = vld_q[LATENCY-1];
    assign taken_o       = pay_q[LATENCY-1].taken;
    assign mispredict_o  = pay_q[LATENCY-1].mis;
    assign target_o      = pay_q[LATENCY-1].target;
    assign link_o        = pay_q[LATENCY-1].link;
    assign redirect_pc_o = pay_q[LATENCY-1].redirect;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] br_cnt_q;
    logic [CNT_W-1:0] mp_cnt_q;
    logic             cf_hs;

    // Counted at the output handshake, so an op leaving during a flush
    // cycle still counts while flushed ops never do.
    assign cf_hs = valid_o & ready_i & pay_q[LATENCY-1].cf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            br_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else if (cf_hs) begin
            if (br_cnt_q != '1) begin
                br_cnt_q <= br_cnt_q + CNT_W'(1);
            end
            if (pay_q[LATENCY-1].mis && (mp_cnt_q != '1)) begin
                mp_cnt_q <= mp_cnt_q + CNT_W'(1);
            end
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mp_cnt_q;
`else
    logic unused_cf;
    assign unused_cf     = pay_q[LATENCY-1].cf;
    assign br_cnt_o      = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bru_resolve_pipe.sv
// tb/tb_bru_resolve_pipe.sv - directed self-checking bench for bru_resolve_pipe
module tb_bru_resolve_pipe;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [31:0] imm_i;
    logic        is_br_i;
    logic        is_jal_i;
    logic        is_jalr_i;
    logic [2:0]  funct3_i;
    logic        pred_taken_i;
    logic [31:0] pred_target_i;
    logic        flush_i;
    logic        valid_o;
    logic        ready_i;
    logic        taken_o;
    logic [31:0] target_o;
    logic [31:0] link_o;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic [3:0]  br_cnt_o;
    logic [3:0]  mispred_cnt_o;

    int errors = 0;
    int checks = 0;
    int br_e   = 0;
    int mp_e   = 0;

    bru_resolve_pipe #(.XLEN(32), .LATENCY(2), .CNT_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .is_br_i(is_br_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .funct3_i(funct3_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i), .flush_i(flush_i),
        .valid_o(valid_o), .ready_i(ready_i), .taken_o(taken_o), .target_o(target_o),
        .link_o(link_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .br_cnt_o(br_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bump(input logic cf, input logic mis);
        if (cf) begin
            if (br_e < 15) br_e++;
            if (mis && mp_e < 15) mp_e++;
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef BRU_PERF_CNT_EN
        chk({tag, ".br_cnt"}, 32'(br_cnt_o), br_e);
        chk({tag, ".mp_cnt"}, 32'(mispred_cnt_o), mp_e);
`else
        chk({tag, ".br_cnt"}, 32'(br_cnt_o), 32'd0);
        chk({tag, ".mp_cnt"}, 32'(mispred_cnt_o), 32'd0);
`endif
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic br, input logic jal, input logic jalr,
                          input logic [2:0] f3, input logic pt, input logic [31:0] ptgt);
        pc_i = pc; rs1_data_i = rs1; rs2_data_i = rs2; imm_i = imm;
        is_br_i = br; is_jal_i = jal; is_jalr_i = jalr; funct3_i = f3;
        pred_taken_i = pt; pred_target_i = ptgt;
    endtask

    // One op through an empty pipe with ready_i high: accept, latency,
    // result, drain, counters.
    task automatic run_op(input string tag, input logic [31:0] pc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] imm, input logic br,
                          input logic jal, input logic jalr, input logic [2:0] f3,
                          input logic pt, input logic [31:0] ptgt, input logic e_tk,
                          input logic [31:0] e_tgt, input logic e_mis, input logic [31:0] e_rd);
        set_op(pc, rs1, rs2, imm, br, jal, jalr, f3, pt, ptgt);
        valid_i = 1'b1; ready_i = 1'b1;
        #1;
        chk({tag, ".ready"}, 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk({tag, ".latency"}, 32'(valid_o), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, ".valid"}, 32'(valid_o), 32'd1);
        chk({tag, ".taken"}, 32'(taken_o), 32'(e_tk));
        chk({tag, ".target"}, target_o, e_tgt);
        chk({tag, ".link"}, link_o, pc + 32'd4);
        chk({tag, ".mispred"}, 32'(mispredict_o), 32'(e_mis));
        chk({tag, ".redirect"}, redirect_pc_o, e_rd);
        bump(br | jal | jalr, e_mis);
        @(posedge clk_i); #1;
        chk({tag, ".drain"}, 32'(valid_o), 32'd0);
        chk_cnt(tag);
    endtask

    initial begin
        int sent;
        int rcvd;
        int seen;
        logic        held_v;
        logic [31:0] held_link;

        rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
        set_op(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.taken", 32'(taken_o), 32'd0);
        chk("rst.target", target_o, 32'd0);
        chk("rst.link", link_o, 32'd0);
        chk("rst.mispred", 32'(mispredict_o), 32'd0);
        chk("rst.redirect", redirect_pc_o, 32'd0);
        chk_cnt("rst");
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        //      tag     pc            rs1           rs2           imm           br jal jalr f3      pt  ptgt          tk  target        mis redirect
        run_op("beq",   32'h100,      32'd5,        32'd5,        32'h20,       1, 0, 0, 3'b000, 1, 32'h120,      1, 32'h120,      0, 32'h120);
        run_op("blt",   32'h200,      32'h80000000, 32'd1,        32'h40,       1, 0, 0, 3'b100, 1, 32'h240,      1, 32'h240,      0, 32'h240);
        run_op("bltu",  32'h200,      32'h80000000, 32'd1,        32'h40,       1, 0, 0, 3'b110, 1, 32'h240,      0, 32'h240,      1, 32'h204);
        run_op("jalr",  32'h300,      32'h1001,     32'd0,        32'h4,        0, 0, 1, 3'b000, 1, 32'h1004,     1, 32'h1004,     0, 32'h1004);
        run_op("jalrm", 32'h300,      32'h1001,     32'd0,        32'h4,        0, 0, 1, 3'b000, 1, 32'h1000,     1, 32'h1004,     1, 32'h1004);
        run_op("bne",   32'h400,      32'd5,        32'd5,        32'hFFFFFFF8, 1, 0, 0, 3'b001, 0, 32'h0,        0, 32'h3F8,      0, 32'h404);
        run_op("bge",   32'h500,      32'hFFFFFFFF, 32'd1,        32'h10,       1, 0, 0, 3'b101, 1, 32'h510,      0, 32'h510,      1, 32'h504);
        run_op("bgeu",  32'h600,      32'hFFFFFFFF, 32'd1,        32'h10,       1, 0, 0, 3'b111, 1, 32'h0,        1, 32'h610,      1, 32'h610);
        run_op("f010",  32'h700,      32'd0,        32'd0,        32'h10,       1, 0, 0, 3'b010, 0, 32'h0,        0, 32'h710,      0, 32'h704);
        run_op("jalpri",32'hFFFFFFF0, 32'd3,        32'd3,        32'h20,       1, 1, 0, 3'b001, 0, 32'h0,        1, 32'h10,       1, 32'h10);
        run_op("nocf",  32'h800,      32'd1,        32'd1,        32'h10,       0, 0, 0, 3'b000, 0, 32'h0,        0, 32'h810,      0, 32'h804);
        run_op("bltovf",32'h900,      32'h7FFFFFFF, 32'hFFFFFFFF, 32'h10,       1, 0, 0, 3'b100, 1, 32'h910,      0, 32'h910,      1, 32'h904);

        // Flush: two ops held with ready_i low, then a third offered together
        // with flush_i while the oldest completes its output handshake.
        ready_i = 1'b0;
        set_op(32'hA00, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        valid_i = 1'b1;
        #1 chk("fl.rdyA", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        set_op(32'hB00, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        #1 chk("fl.rdyB", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        set_op(32'hC00, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        flush_i = 1'b1; ready_i = 1'b1;
        #1;
        chk("fl.valid", 32'(valid_o), 32'd1);
        chk("fl.linkA", link_o, 32'hA04);
        chk("fl.rdyC", 32'(ready_o), 32'd1);
        bump(1'b1, 1'b1);
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("fl.clear", 32'(valid_o), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge clk_i); #1;
            if (valid_o) seen++;
        end
        chk("fl.ghost", seen, 32'd0);
        chk_cnt("fl");
        run_op("postfl", 32'hD00, 32'd2, 32'd3, 32'h40, 1, 0, 0, 3'b001, 1, 32'hD40, 1, 32'hD40, 0, 32'hD40);

        // Stream of 6 ops with ready_i toggling 1010...
        sent = 0; rcvd = 0; held_v = 1'b0; held_link = 32'h0;
        for (int c = 0; c < 80 && rcvd < 6; c++) begin
            ready_i = (c % 2 == 0);
            valid_i = (sent < 6);
            set_op(32'h1000 + 32'(sent) * 32'h100, 32'(sent), 32'(sent), 32'h8, 1'b1, 1'b0, 1'b0,
                   3'b000, 1'b1, 32'h1008 + 32'(sent) * 32'h100);
            #1;
            if (held_v) begin
                chk("st.hold_valid", 32'(valid_o), 32'd1);
                chk("st.hold_link", link_o, held_link);
            end
            if (valid_o && ready_i) begin
                chk("st.order", link_o, 32'h1004 + 32'(rcvd) * 32'h100);
                chk("st.mispred", 32'(mispredict_o), 32'd0);
                bump(1'b1, 1'b0);
                rcvd++;
            end
            held_v = valid_o && !ready_i;
            held_link = link_o;
            if (valid_i && ready_o) sent++;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0; ready_i = 1'b1;
        chk("st.count", rcvd, 32'd6);
        chk("st.empty", 32'(valid_o), 32'd0);
        chk_cnt("st");

        // 20 mispredicted branches back to back: counters saturate.
        sent = 0; rcvd = 0;
        for (int c = 0; c < 100 && rcvd < 20; c++) begin
            valid_i = (sent < 20);
            set_op(32'h2000 + 32'(sent) * 32'h10, 32'd7, 32'd7, 32'h8, 1'b1, 1'b0, 1'b0,
                   3'b000, 1'b0, 32'h0);
            #1;
            if (valid_o && ready_i) begin
                if (rcvd == 0) chk("sat.mispred", 32'(mispredict_o), 32'd1);
                bump(1'b1, 1'b1);
                rcvd++;
            end
            if (valid_i && ready_o) sent++;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        chk("sat.count", rcvd, 32'd20);
        chk_cnt("sat");

        // Asynchronous reset with ops in flight.
        ready_i = 1'b0;
        set_op(32'hE00, 32'd4, 32'd4, 32'h20, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 32'h0);
        valid_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        chk("ar.pre_valid", 32'(valid_o), 32'd1);
        chk("ar.pre_target", target_o, 32'hE20);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar.valid", 32'(valid_o), 32'd0);
        chk("ar.taken", 32'(taken_o), 32'd0);
        chk("ar.target", target_o, 32'd0);
        chk("ar.link", link_o, 32'd0);
        chk("ar.mispred", 32'(mispredict_o), 32'd0);
        chk("ar.redirect", redirect_pc_o, 32'd0);
        br_e = 0; mp_e = 0;
        chk_cnt("ar");
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        run_op("postrst", 32'hF00, 32'd9, 32'd1, 32'h30, 1, 0, 0, 3'b000, 1, 32'hF30, 0, 32'hF30, 1, 32'hF04);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
